// File: rtl/byte_port_arbiter_pkg.sv
// Shared types and constants for the byte-wide round-robin port arbiter.
package byte_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_BURST_DEF = 16;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/byte_port_arbiter_if.sv
// Requester-side and sink-side streaming signals of the arbiter.
// The master modport is the arbiter itself; slave is the surrounding logic.
interface byte_port_arbiter_if
    import byte_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_ready;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/byte_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr,
// wrapping modulo N_REQ.
module rr_priority_picker
    import byte_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_rr_ptr,
    output logic [ID_W-1:0]  o_winner,
    output logic             o_any_req
);

    logic [N_REQ-1:0] w_rot;
    int               w_sum;

    // Rotate so bit 0 is the pointer position; scanning downward leaves the
    // lowest rotated bit (closest to the pointer) as the final winner.
    always_comb begin
        w_rot     = N_REQ'({i_req, i_req} >> i_rr_ptr);
        o_any_req = |i_req;
        o_winner  = '0;
        w_sum     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = int'(i_rr_ptr) + k;
                if (w_sum >= N_REQ) begin
                    w_sum = w_sum - N_REQ;
                end
                o_winner = ID_W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/byte_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide valid/ready output between
// N_REQ requesters; a grant is held for a whole burst (last beat or MAX_BURST).
module byte_port_arbiter
    import byte_arb_pkg::*;
#(
    parameter  int N_REQ     = N_REQ_DEF,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int ID_W      = clog2_min1(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    byte_port_arbiter_if.master bus,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

    arb_state_t       r_state,    w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr,   w_rr_ptr_nxt;
    logic [ID_W-1:0]  r_grant_id, w_grant_id_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

    logic [ID_W-1:0]  w_winner;
    logic             w_any_req;
    logic             w_out_valid;
    logic             w_out_last;
    logic             w_accept;

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_req     (bus.req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // The owner's handshake is passed straight through; the grant only moves
    // after an accepted beat carrying out_last (requester last or forced cap).
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_out_valid    = 1'b0;
        w_out_last     = 1'b0;
        w_accept       = 1'b0;
        bus.req_ready  = '0;
        bus.out_data   = '0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_id_nxt = w_winner;
                    w_state_nxt    = XFER;
                end
            end
            XFER: begin
                w_out_valid               = bus.req_valid[r_grant_id];
                bus.out_data              = bus.req_data[int'(r_grant_id)*DATA_W +: DATA_W];
                bus.req_ready[r_grant_id] = bus.out_ready;
                w_out_last                = bus.req_last[r_grant_id] | (r_beat_cnt == LAST_BEAT);
                w_accept                  = w_out_valid & bus.out_ready;
                if (w_accept) begin
                    if (w_out_last) begin
                        w_state_nxt    = IDLE;
                        w_beat_cnt_nxt = '0;
                        w_rr_ptr_nxt   = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        bus.out_valid = w_out_valid;
        bus.out_last  = w_out_last;
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state == XFER);

endmodule

// File: doc/byte_port_arbiter.md
Name: byte_port_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit streaming output port between N_REQ requesters using a valid/ready handshake.
- Grants are held for a whole burst. A burst ends on the requester's last beat or when the beat count reaches MAX_BURST.
- Sits in front of any byte-wide sink (e.g. an 8-bit data input port) that several upstream blocks must drive.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, beat width in bits.
- MAX_BURST, 16, maximum beats per grant (1..256).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous active-low reset: asserts immediately on low, deasserts synchronously to clk.
- req_valid  input  N_REQ  per-requester beat valid.
- req_data  input  N_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  N_REQ  per-requester end-of-burst marker.
- req_ready  output  N_REQ  per-requester ready; at most one bit high.
- out_valid  output  1  beat valid to sink.
- out_data  output  DATA_W  beat data to sink.
- out_last  output  1  end of burst to sink.
- out_ready  input  1  sink ready.
- grant_id  output  $clog2(N_REQ)  index of the current owner; valid while busy=1.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset values (rst low): state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, out_valid=0, out_last=0, out_data=0, req_ready=0.
- States:
  - IDLE: no grant; all outputs idle. If any req_valid is high, the priority picker chooses the first set bit at or after rr_ptr, wrapping modulo N_REQ. The winner is registered into grant_id and the state moves to XFER on the next edge.
  - XFER: combinational pass-through from requester g=grant_id:
    - out_valid = req_valid[g], out_data = req_data[g].
    - req_ready[g] = out_ready; all other req_ready bits are 0.
    - out_last = req_last[g] OR (beat_cnt == MAX_BURST-1).
    - A beat is accepted when out_valid && out_ready; each accepted beat increments beat_cnt.
    - An accepted beat with out_last=1 ends the burst: next state IDLE, beat_cnt=0, rr_ptr=(g+1) mod N_REQ.
- Latency: one cycle from req_valid in IDLE to the first possible accepted beat. There is one IDLE bubble cycle between consecutive bursts.
- Hold rule: the grant never changes mid-burst, even if req_valid[g] drops. The arbiter waits in XFER with out_valid low.
- Forced termination: at MAX_BURST the arbiter asserts out_last even if req_last[g]=0. The requester simply loses the grant; its remaining beats are served on its next grant.
- Arbitration ignores the values of req_last and req_data.
- Simultaneous requests: the first requester at or after rr_ptr wins. Ties are impossible.
- No requests in IDLE: remain in IDLE, rr_ptr unchanged.
- Reset mid-burst: all state clears immediately. The partial burst is abandoned with no out_last issued, and the sink must tolerate this.
- busy = (state==XFER).
- Width rules: beat_cnt is $clog2(MAX_BURST+1) bits and saturates are impossible by construction. rr_ptr and grant_id are $clog2(N_REQ) bits and wrap modulo N_REQ. For non-power-of-2 N_REQ, wrap is explicit.

Decomposition:
- Package byte_arb_pkg holds:
  - the state enum (IDLE, XFER);
  - default constants N_REQ_DEF=4 and MAX_BURST_DEF=16;
  - the function clog2_min1 (returns at least 1).
- Sub-module rr_priority_picker: combinational. Inputs are req vector and rr_ptr; outputs are winner index and any_req. It is unit-tested separately.

Test Plan:
- Reset: hold rst low for 3 cycles with all req_valid=1 -> busy=0, req_ready=0, out_valid=0. After release, the first grant is to id 0.
- Single burst: req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3 and out_ready=1 -> grant_id=2, out_data matches in order, out_last only on beat 3, IDLE for 1 cycle, rr_ptr=3.
- Round-robin fairness: all 4 requesters continuously valid with 1-beat bursts (last=1) -> grant order 0,1,2,3,0,1; each receives exactly 1 beat per 8 cycles.
- Forced termination: req 1 streams 20 beats with last=0 and MAX_BURST=16 -> out_last asserted on beat 16, grant passes to the next requester, and req 1's beat 17 arrives on a later grant.
- Backpressure and gaps: out_ready toggles 1,0,0,1 and req_valid[g] drops for 2 cycles mid-burst -> no beat lost or duplicated, grant held, beat_cnt advances only on handshakes.
- Reset mid-burst: rst pulses low after beat 5 of a burst -> outputs clear the same cycle, beat_cnt=0, rr_ptr=0, normal arbitration resumes after release.
